// File: rtl/reverb_mem_sequencer.sv
// reverb_mem_sequencer: feedback comb reverb y[n] = x[n] + alpha*y[n-DELAY] over a single-port RAM
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   i_start            one-cycle pulse, accepted only when idle
//   i_sample_count     sample count N, latched on accepted start
//   i_alpha            signed Q1.15 feedback gain, latched on accepted start
//   o_busy, o_done     pass in progress / one-cycle completion pulse
//   o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata   registered RAM master bus
// Build option: define REVERB_SAT_EN to saturate y to 16 bits instead of wrapping.
module reverb_mem_sequencer #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 100000,
    parameter int DELAY    = 2205,
    parameter int FRAC     = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_sample_count,
    input  logic [15:0]       i_alpha,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam logic [ADDR_W-1:0] L_IN    = ADDR_W'(IN_BASE);
    localparam logic [ADDR_W-1:0] L_OUT   = ADDR_W'(OUT_BASE);
    localparam logic [ADDR_W-1:0] L_DELAY = ADDR_W'(DELAY);

    typedef enum logic [2:0] {S_IDLE, S_RX, S_CX, S_RY, S_CY, S_WR, S_FIN} state_t;

    state_t              r_state, w_state;
    logic [ADDR_W-1:0]   r_n, w_n, r_cnt, w_cnt, r_addr, w_addr;
    logic [15:0]         r_alpha, w_alpha, r_x, w_x;
    logic                r_busy, w_busy, r_done, w_done, r_we, w_we;
    logic [DATA_W-1:0]   r_wdata, w_wdata;
    logic                w_early;
    logic [15:0]         w_rd;
    logic signed [15:0]  w_yd;
    logic signed [31:0]  w_p;
    logic [16:0]         w_s;
    logic [17:0]         w_sum;
    logic [15:0]         w_y;

    assign w_early = r_n < L_DELAY;
    assign w_rd    = 16'(i_mem_rdata);
    // y[n-DELAY] is consumed straight off the bus in CY so y is ready for the registered write
    assign w_yd    = w_early ? 16'sd0 : $signed(w_rd);
    assign w_p     = $signed(r_alpha) * w_yd;
    assign w_s     = 17'(w_p >>> FRAC);
    assign w_sum   = {{2{r_x[15]}}, r_x} + {w_s[16], w_s};
`ifdef REVERB_SAT_EN
    assign w_y     = (w_sum[17:15] == 3'b000 || w_sum[17:15] == 3'b111) ? 16'(w_sum) :
                     (w_sum[17] ? 16'h8000 : 16'h7FFF);
`else
    assign w_y     = 16'(w_sum);
`endif

    always_comb begin
        w_state = r_state;
        w_n     = r_n;
        w_cnt   = r_cnt;
        w_alpha = r_alpha;
        w_x     = r_x;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_cnt   = i_sample_count;
                w_alpha = i_alpha;
                w_n     = '0;
                w_busy  = 1'b1;
                w_state = (i_sample_count == '0) ? S_FIN : S_RX;
                w_addr  = (i_sample_count == '0) ? r_addr : L_IN;
            end
            S_RX: w_state = S_CX;
            S_CX: begin
                w_state = S_RY;
                w_x     = w_rd;
                w_addr  = w_early ? L_OUT : L_OUT + r_n - L_DELAY;
            end
            S_RY: w_state = S_CY;
            S_CY: begin
                w_state = S_WR;
                w_addr  = L_OUT + r_n;
                w_we    = 1'b1;
                w_wdata = {{(DATA_W-16){w_y[15]}}, w_y};
            end
            S_WR: if (r_n == r_cnt - 1'b1) begin
                w_state = S_FIN;
            end else begin
                w_state = S_RX;
                w_n     = r_n + 1'b1;
                w_addr  = L_IN + r_n + 1'b1;
            end
            S_FIN: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_done  = 1'b1;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_cnt   <= '0;
            r_alpha <= '0;
            r_x     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state;
            r_n     <= w_n;
            r_cnt   <= w_cnt;
            r_alpha <= w_alpha;
            r_x     <= w_x;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
endmodule

// File: doc/reverb_mem_sequencer.md
Name: reverb_mem_sequencer

Overview:
- Bus initiator for the single-port data RAM (`clk`, `we`, 18-bit address, 32-bit write/read data) holding the audio buffers.
- Walks an input buffer and computes a feedback comb reverb, y[n] = x[n] + alpha·y[n−DELAY]. Each y[n] is written to an output buffer in the same RAM.
- Sits between the control/start logic and the data RAM, and is the only master on the RAM bus while busy.

Parameters:
- ADDR_W, 18: RAM address width.
- DATA_W, 32: RAM data width.
- IN_BASE, 0: word address of x[0].
- OUT_BASE, 100000: word address of y[0]. sample_count must be ≤ OUT_BASE − IN_BASE and OUT_BASE + sample_count ≤ 2^ADDR_W.
- DELAY, 2205: comb delay in samples (50 ms at 44.1 kHz). Must be ≥ 1.
- FRAC, 15: fractional bits of alpha (Q1.15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; starts a pass when idle.
- sample_count  in  ADDR_W  number of samples N; latched on accepted start.
- alpha  in  16  signed Q1.15 feedback gain; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when a pass completes.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, n=0, state=IDLE.
- Reset asserted mid-pass forces these values immediately (mem_we drops without waiting for a clock edge). The pass is abandoned and any partially written output stays in RAM.
- All mem_* outputs are registered.
- Sample format: signed 16-bit value in bits [15:0]. Bits [31:16] are ignored on read. Writes sign-extend bit 15 into [31:16].

State machine (one state per cycle):
- IDLE: wait for start. On start, latch N and alpha, clear n, set busy.
  - If N=0: go to FIN. No RAM access.
  - Otherwise: go to RX.
  - start is ignored in every state except IDLE.
- RX: mem_addr=IN_BASE+n, mem_we=0.
- CX: mem_addr held. mem_rdata is captured into x at the edge leaving CX. This is valid for both an asynchronous-read RAM and a 1-cycle registered-read RAM.
- RY: mem_addr=OUT_BASE+n−DELAY, mem_we=0.
- CY: mem_addr held; mem_rdata is captured into yd.
  - If n<DELAY, RY and CY still execute (fixed timing), mem_addr=OUT_BASE, and yd is forced to 0.
- WR: mem_addr=OUT_BASE+n, mem_wdata=y, mem_we=1 for exactly one cycle.
  - If n=N−1: go to FIN.
  - Otherwise: n←n+1 and go to RX.
- FIN: done=1 for one cycle, busy=0, then IDLE.
- Timing: exactly 5 cycles per sample. done is asserted 5N+1 cycles after the start edge (1 cycle when N=0).
- mem_we is 1 only in WR.

Arithmetic:
- p = signed(alpha)·signed(yd), a 32-bit product.
- s = p >>> FRAC (arithmetic shift, floor).
- sum = sext18(x) + sext18(s[16:0]).
- y = sat16(sum) or wrap16(sum), selected by the optional feature below.

Optional Feature:
- Macro: REVERB_SAT_EN.
- Defined: y is saturated to [−32768, 32767].
- Undefined: y = sum[15:0], two's-complement wrap, with no saturation logic.
- Cycle timing is identical in both builds.

Test Plan:
- Impulse: DELAY=2, N=4, alpha=0x4000, x={1000,0,0,0} → writes OUT_BASE..+3 = {1000,0,500,0}. done is asserted 21 cycles after start.
- Positive overflow: DELAY=1, N=2, alpha=0x7FFF, x={30000,30000} → y[1]=32767 (0x00007FFF) with REVERB_SAT_EN; −5537 (0xFFFFEA5F) without.
- Negative overflow/sign extension: DELAY=1, N=2, alpha=0x7FFF, x={−30000,−20000} → y[1]=−32768 (0xFFFF8000) with REVERB_SAT_EN. Upper 16 bits are all ones.
- Zero length: N=0, start → no mem_we pulse; done=1 exactly one cycle later; busy is high for 1 cycle.
- Start while busy: second start pulse during pass of N=3 → ignored. Exactly 3 writes, one done pulse at cycle 16.
- Reset mid-pass: assert rst in a WR cycle of N=8 → mem_we, busy and done go to 0 without a clock edge. After release, a new start with N=1 runs normally (done at cycle 6).
